// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver.
//   seg_t        : active-low glyph, index 0 = segment a ... index 6 = segment g
//   SEG_BLANK    : all segments dark
//   SEG_MINUS    : segment g only
//   SEG_DIGIT    : glyphs for codes 0..15 (0-9 decimal, 10-15 hex A,b,C,d,E,F)
//   CODE_MINUS   : code that renders as a minus sign when hex mode is off
//   idx_width()  : width of the scan index register for a given digit count
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Ascending range so that a literal written "abcdefg" lands a on index 0.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_MINUS = 7'b1111110;

    localparam logic [3:0] CODE_MINUS = 4'd10;

    localparam seg_t SEG_DIGIT [0:15] = '{
        7'b0000001,     // 0
        7'b1001111,     // 1
        7'b0010010,     // 2
        7'b0000110,     // 3
        7'b1001100,     // 4
        7'b0100100,     // 5
        7'b0100000,     // 6
        7'b0001111,     // 7
        7'b0000000,     // 8
        7'b0001100,     // 9
        7'b0001000,     // A
        7'b1100000,     // b
        7'b0110001,     // C
        7'b1000010,     // d
        7'b0110000,     // E
        7'b0111000      // F
    };

    // Scan index width; never narrower than one bit.
    function automatic int idx_width(input int num_digits);
        return (num_digits <= 2) ? 1 : $clog2(num_digits);
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// -----------------------------------------------------------------------------
// seg7_glyph
// Combinational 4-bit code to active-low seven-segment glyph decoder.
//   code     : digit code 0..15
//   hex_mode : 1 = codes 10..15 render A,b,C,d,E,F
//              0 = code 10 renders minus, codes 11..15 render blank
//   segments : active-low a..g (index 0 = a)
// -----------------------------------------------------------------------------
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output seg_t       segments
);

    always_comb begin
        segments = SEG_BLANK;
        if (hex_mode || (code < CODE_MINUS)) begin
            segments = SEG_DIGIT[code];
        end else if (code == CODE_MINUS) begin
            segments = SEG_MINUS;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed controller for an N-digit common-anode seven-segment display.
// A prescaler keeps each digit lit for REFRESH_DIV cycles; the scan walks from
// the leftmost digit (NUM_DIGITS-1) down to digit 0 and wraps. Display data is
// loaded into a staging buffer and only copied into the shadow (displayed)
// buffer at a frame boundary, so a frame never shows a mix of old and new data.
//
// Ports
//   clk          : system clock
//   reset        : synchronous, active-high
//   enable       : 0 = all anodes off, prescaler and scan index hold
//   load         : 1-cycle strobe capturing digits_in/dp_in/blank_in
//   digits_in    : digit k code at [4k+3:4k]; k = NUM_DIGITS-1 is leftmost
//   dp_in        : 1 = decimal point lit on digit k
//   blank_in     : 1 = digit k forced dark (segments and dp)
//   anode_active : active-low digit select, one-hot-zero at the scan index
//   segments     : active-low a..g (index 0 = a)
//   dp           : active-low decimal point
//   frame_tick   : 1-cycle pulse the cycle after each frame boundary
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit HEX_MODE    = 1'b0,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   anode_active,
    output logic [0:6]              segments,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int IDX_W   = idx_width(NUM_DIGITS);
    localparam int PRESC_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;

    logic [4*NUM_DIGITS-1:0] r_stage_digits;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [NUM_DIGITS-1:0]   r_stage_blank;
    logic                    r_pending;

    logic [4*NUM_DIGITS-1:0] r_shadow_digits;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;

    logic [NUM_DIGITS-1:0]   r_anode;
    seg_t                    r_segments;
    logic                    r_dp;
    logic                    r_frame_tick;

    // ---------------------------------------------------------------------
    // Prescaler and scan index
    // ---------------------------------------------------------------------
    logic                    w_presc_tc;
    logic                    w_boundary;
    logic [PRESC_W-1:0]      w_presc_next;
    logic [IDX_W-1:0]        w_idx_next;

    assign w_presc_tc = enable && (r_presc == PRESC_LAST);
    // The frame boundary is the step from digit 0 back to the leftmost digit.
    assign w_boundary = w_presc_tc && (r_idx == '0);

    always_comb begin
        w_presc_next = r_presc;
        w_idx_next   = r_idx;
        if (enable) begin
            if (w_presc_tc) begin
                w_presc_next = '0;
                w_idx_next   = (r_idx == '0) ? IDX_LAST : (r_idx - IDX_ONE);
            end else begin
                w_presc_next = r_presc + PRESC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= IDX_LAST;
        end else begin
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
        end
    end

    // ---------------------------------------------------------------------
    // Staging / shadow buffers
    // A load that lands exactly on a boundary bypasses staging so the new
    // data is shown for the whole frame that is just starting.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_digits  <= '0;
            r_stage_dp      <= '0;
            r_stage_blank   <= '0;
            r_pending       <= 1'b0;
            r_shadow_digits <= '0;
            r_shadow_dp     <= '0;
            r_shadow_blank  <= '0;
        end else begin
            if (load) begin
                r_stage_digits <= digits_in;
                r_stage_dp     <= dp_in;
                r_stage_blank  <= blank_in;
            end

            if (load && w_boundary) begin
                r_shadow_digits <= digits_in;
                r_shadow_dp     <= dp_in;
                r_shadow_blank  <= blank_in;
                r_pending       <= 1'b0;
            end else if (load) begin
                r_pending       <= 1'b1;
            end else if (w_boundary && r_pending) begin
                r_shadow_digits <= r_stage_digits;
                r_shadow_dp     <= r_stage_dp;
                r_shadow_blank  <= r_stage_blank;
                r_pending       <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-digit view of the shadow buffer and leading-zero detection
    // ---------------------------------------------------------------------
    logic [3:0]            w_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_is_zero;
    logic [NUM_DIGITS-1:0] w_zero_run;   // digit k and everything left of it is 0, no dp
    logic [NUM_DIGITS-1:0] w_lz_dark;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_code[gi]    = r_shadow_digits[4*gi +: 4];
        assign w_is_zero[gi] = (w_code[gi] == 4'd0) && !r_shadow_dp[gi];

        // Digit 0 always shows something, even when the whole value is zero.
        if (gi == 0) begin : g_units
            assign w_lz_dark[gi] = 1'b0;
        end else begin : g_upper
            assign w_lz_dark[gi] = LZ_SUPPRESS && w_zero_run[gi];
        end
    end

    // Chained inside one process so the run propagates from the left edge.
    always_comb begin
        w_zero_run = '0;
        w_zero_run[NUM_DIGITS-1] = w_is_zero[NUM_DIGITS-1];
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            w_zero_run[k] = w_zero_run[k+1] && w_is_zero[k];
        end
    end

    // ---------------------------------------------------------------------
    // Selected digit decode
    // ---------------------------------------------------------------------
    logic [3:0] w_sel_code;
    logic       w_sel_dark;
    seg_t       w_glyph;

    assign w_sel_code = w_code[r_idx];
    assign w_sel_dark = r_shadow_blank[r_idx] || w_lz_dark[r_idx];

    seg7_glyph u_glyph (
        .code     (w_sel_code),
        .hex_mode (HEX_MODE),
        .segments (w_glyph)
    );

    // ---------------------------------------------------------------------
    // Registered pin drivers (one cycle behind the scan index)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode      <= '1;
            r_segments   <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (!enable) begin
                r_anode    <= '1;
                r_segments <= SEG_BLANK;
                r_dp       <= 1'b1;
            end else begin
                r_anode    <= ~(NUM_DIGITS'(1) << r_idx);
                r_segments <= w_sel_dark ? SEG_BLANK : w_glyph;
                r_dp       <= w_sel_dark ? 1'b1 : !r_shadow_dp[r_idx];
            end
        end
    end

    assign anode_active = r_anode;
    assign segments     = r_segments;
    assign dp           = r_dp;
    assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Two instances share one stimulus stream: a BCD build with leading-zero
// suppression and a hex build without it. A reference model works from the
// count of enabled cycles since reset (which digit is lit, when a frame ends)
// and from "what data is on screen / what is waiting", and pushes the expected
// pin values for every clock edge into a queue; a monitor pops and compares
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     = 1'b1;
    logic        enable    = 1'b1;
    logic        load      = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in     = '0;
    logic [3:0]  blank_in  = '0;

    logic [3:0]  anode_b, anode_h;
    logic [0:6]  seg_b, seg_h;
    logic        dp_b, dp_h, tick_b, tick_h;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1'b0), .LZ_SUPPRESS(1'b1)) u_dut_bcd (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .anode_active(anode_b), .segments(seg_b), .dp(dp_b), .frame_tick(tick_b)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1'b1), .LZ_SUPPRESS(1'b0)) u_dut_hex (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .anode_active(anode_h), .segments(seg_h), .dp(dp_h), .frame_tick(tick_h)
    );

    typedef struct packed {
        logic [3:0] anode;
        logic [0:6] seg_b;
        logic       dp_b;
        logic [0:6] seg_h;
        logic       dp_h;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_load = 0;

    // ---------------- reference model state ----------------
    int          en_cnt = 0;        // enabled cycles since reset
    logic [15:0] shown_digits = '0;
    logic [3:0]  shown_dp     = '0;
    logic [3:0]  shown_blank  = '0;
    logic [15:0] new_digits   = '0;
    logic [3:0]  new_dp       = '0;
    logic [3:0]  new_blank    = '0;
    bit          have_new     = 1'b0;

    function automatic logic [0:6] ref_glyph(input logic [3:0] code, input bit hex);
        case (code)
            4'd0:  return 7'b0000001;
            4'd1:  return 7'b1001111;
            4'd2:  return 7'b0010010;
            4'd3:  return 7'b0000110;
            4'd4:  return 7'b1001100;
            4'd5:  return 7'b0100100;
            4'd6:  return 7'b0100000;
            4'd7:  return 7'b0001111;
            4'd8:  return 7'b0000000;
            4'd9:  return 7'b0001100;
            4'd10: return hex ? 7'b0001000 : 7'b1111110;
            4'd11: return hex ? 7'b1100000 : 7'b1111111;
            4'd12: return hex ? 7'b0110001 : 7'b1111111;
            4'd13: return hex ? 7'b1000010 : 7'b1111111;
            4'd14: return hex ? 7'b0110000 : 7'b1111111;
            default: return hex ? 7'b0111000 : 7'b1111111;
        endcase
    endfunction

    function automatic void ref_digit(input int k, input bit hex, input bit lz,
                                      output logic [0:6] seg, output logic dpo);
        bit dark;
        bit all_zero;
        dark = shown_blank[k];
        if (lz && k != 0) begin
            all_zero = 1'b1;
            for (int j = N - 1; j >= k; j--) begin
                if (shown_digits[4*j +: 4] != 4'd0 || shown_dp[j]) all_zero = 1'b0;
            end
            if (all_zero) dark = 1'b1;
        end
        seg = dark ? 7'b1111111 : ref_glyph(shown_digits[4*k +: 4], hex);
        dpo = dark ? 1'b1 : !shown_dp[k];
    endfunction

    initial begin : model
        exp_t e;
        int   d;
        bit   bnd;
        forever begin
            @(posedge clk);
            e = '1;
            e.tick = 1'b0;
            if (reset) begin
                en_cnt       = 0;
                shown_digits = '0; shown_dp = '0; shown_blank = '0;
                new_digits   = '0; new_dp   = '0; new_blank   = '0;
                have_new     = 1'b0;
            end else begin
                d   = N - 1 - ((en_cnt / RD) % N);
                bnd = enable && (((en_cnt + 1) % FRAME) == 0);
                if (enable) begin
                    e.anode[d] = 1'b0;
                    ref_digit(d, 1'b0, 1'b1, e.seg_b, e.dp_b);
                    ref_digit(d, 1'b1, 1'b0, e.seg_h, e.dp_h);
                end
                e.tick = bnd;
                if (load && bnd) begin
                    shown_digits = digits_in; shown_dp = dp_in; shown_blank = blank_in;
                    have_new = 1'b0;
                end else if (load) begin
                    new_digits = digits_in; new_dp = dp_in; new_blank = blank_in;
                    have_new = 1'b1;
                end else if (bnd && have_new) begin
                    shown_digits = new_digits; shown_dp = new_dp; shown_blank = new_blank;
                    have_new = 1'b0;
                end
                if (enable) en_cnt++;
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("anode_bcd", {4'b0, anode_b}, {4'b0, e.anode});
                check("anode_hex", {4'b0, anode_h}, {4'b0, e.anode});
                check("seg_bcd",   {1'b0, seg_b},   {1'b0, e.seg_b});
                check("seg_hex",   {1'b0, seg_h},   {1'b0, e.seg_h});
                check("dp_bcd",    {7'b0, dp_b},    {7'b0, e.dp_b});
                check("dp_hex",    {7'b0, dp_h},    {7'b0, e.dp_h});
                check("tick_bcd",  {7'b0, tick_b},  {7'b0, e.tick});
                check("tick_hex",  {7'b0, tick_h},  {7'b0, e.tick});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        load = 1'b1; digits_in = d; dp_in = p; blank_in = b;
        n_load++;
        $display("load %0d: digits=%h dp=%b blank=%b en=%b rst=%b @%0t",
                 n_load, d, p, b, enable, reset, $time);
        step(1);
        load = 1'b0;
    endtask

    function automatic logic [3:0] rand_code();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin : stim
        int guard;
        step(3);
        reset = 1'b0;
        step(40);                                    // idle scan of all-zero data

        do_load(16'h1234, 4'b0000, 4'b0000);
        step(40);
        step(5);                                     // land mid-frame
        do_load(16'h5678, 4'b0000, 4'b0000);
        step(40);

        do_load(16'h0070, 4'b0000, 4'b0000);
        step(36);
        do_load(16'h0070, 4'b1000, 4'b0000);
        step(36);

        do_load(16'hAF0A, 4'b0100, 4'b0000);         // minus / blank vs hex glyphs
        step(36);
        do_load(16'hBCDE, 4'b0001, 4'b0000);
        step(36);

        do_load(16'h8888, 4'b0000, 4'b0010);
        step(36);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(36);

        // Load exactly on the boundary edge.
        guard = 0;
        while (((en_cnt + 1) % FRAME) != 0 && guard < 4 * FRAME) begin
            step(1);
            guard++;
        end
        if (guard >= 4 * FRAME) begin
            n_bad++;
            $display("FAIL boundary_wait: got no boundary within %0d cycles", guard);
        end
        do_load(16'h4321, 4'b0010, 4'b0000);
        step(36);

        // Reset while a load is pending: that data must never appear.
        step(3);
        do_load(16'h9999, 4'b1111, 4'b0000);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(40);

        // Randomized traffic.
        for (int c = 0; c < 2400; c++) begin
            enable = ($urandom_range(0, 15) != 0);
            reset  = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) begin
                do_load({rand_code(), rand_code(), rand_code(), rand_code()},
                        ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                        ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
            end else begin
                step(1);
            end
        end
        reset  = 1'b0;
        enable = 1'b1;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display controller for an N-digit common-anode display.
- Refresh prescaler and digit scan counter select one digit at a time; per-digit codes are decoded to active-low segments.
- Adds per-digit decimal point, per-digit blanking, leading-zero suppression, hex/BCD mode, and tear-free frame-synchronous data loading.
- Sits between datapath/score logic and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range ≥2.
- HEX_MODE, 0, 1: codes 10..15 show A,b,C,d,E,F; 0: code 10 shows minus (segment g only), codes 11..15 blank.
- LZ_SUPPRESS, 1, 1: blank leading zero digits.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, 0: all anodes off, prescaler and scan index hold.
- load, input, 1, 1-cycle strobe; capture digits_in/dp_in/blank_in into staging.
- digits_in, input, 4*NUM_DIGITS, digit k code at [4k+3:4k]; k=NUM_DIGITS-1 is leftmost/most significant.
- dp_in, input, NUM_DIGITS, 1 = decimal point lit on digit k.
- blank_in, input, NUM_DIGITS, 1 = force digit k dark (segments and dp).
- anode_active, output, NUM_DIGITS, active-low; bit k drives digit k.
- segments, output, [0:6], active-low, index 0 = a … 6 = g.
- dp, output, 1, active-low decimal point.
- frame_tick, output, 1, 1-cycle pulse at each frame boundary.

Behaviour:
- Reset values:
  - Prescaler = 0; scan index = NUM_DIGITS-1.
  - Staging, shadow and pending = 0.
  - anode_active = all 1s; segments = 7'b1111111; dp = 1; frame_tick = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable = 1.
  - At terminal count it wraps to 0 and the scan index steps down: NUM_DIGITS-1 → … → 0 → NUM_DIGITS-1.
- Frame boundary: the step from index 0 to NUM_DIGITS-1.
  - frame_tick = 1 in the cycle after the step (registered).
  - If pending = 1, staging is copied to shadow and pending is cleared, in the same cycle as the step.
- Load handshake:
  - load = 1 copies inputs to staging and sets pending.
  - Repeated loads before a boundary: last one wins.
  - load coincident with a boundary: new inputs go directly to shadow; pending ends 0.
  - The displayed data therefore never changes mid-frame.
- Outputs:
  - Registered; they reflect the current scan index and shadow one cycle after the index changes (latency 1).
  - anode_active has exactly one 0, at the current index.
- Glyph table (active-low a..g):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100
  - minus = 1111110, blank = 1111111
  - Hex: A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Leading-zero suppression:
  - Digit k is dark if LZ_SUPPRESS = 1, k ≠ 0, and every shadow code from NUM_DIGITS-1 down to k is 0 with no dp set among them.
  - Digit 0 is never suppressed.
- Blanking: blank_in[k] overrides everything; segments and dp are dark.
- enable = 0: next cycle anode_active = all 1s; segment and dp values don't care but driven to 1s. Counters hold. Loads are still accepted and frame-synchronous update is deferred.
- Reset mid-frame: synchronous; all state returns to reset values on the next edge, and any pending load is discarded.

Decomposition:
- Package seg7_pkg holds:
  - Glyph constants: SEG_BLANK, SEG_MINUS, SEG_DIGIT[0:15] for BCD and hex.
  - Code constant CODE_MINUS = 4'd10.
  - Localparam helper for the index width, $clog2(NUM_DIGITS).
- One combinational sub-module, seg7_glyph (code, hex_mode → segments), instanced once on the selected digit.
- The scan, prescaler, and staging/shadow logic stay in seg7_scan_driver.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless stated):
- Reset → anode_active = 1111, segments = 1111111, dp = 1. After release, anode_active = 0111 appears within 1 cycle of the first scan, then steps 1011, 1101, 1110 every 4 cycles; frame_tick pulses every 16 cycles.
- load digits_in = 16'h1234 → after the next boundary, the scan shows 1001111, 0010010, 0000110, 1001100 on digits 3..0. A mid-frame load of 16'h5678 does not change digits until the following frame_tick.
- Shadow 16'h0070, LZ_SUPPRESS=1 → digits 3,2 dark; digit 1 shows 0001111; digit 0 shows 0000001. Same data with dp_in = 4'b1000 → digit 3 shows 0 and dp = 0.
- HEX_MODE=0, code 4'hA → 1111110. HEX_MODE=1, code 4'hA → 0001000, code 4'hF → 0111000.
- blank_in = 4'b0010 with data 8888 → digit 1 dark, others 0000000. enable = 0 for 10 cycles → anode_active = 1111 and the scan index resumes unchanged.
- load asserted in the same cycle as a boundary → new data is visible in that frame and pending = 0. Reset asserted mid-frame with pending = 1 → the pending data never appears.
